// File: rtl/reg_status_table.sv
// Register status / rename table for the Tomasulo issue stage.
// Ports: clk, rst (sync, active-high); read req in_enable/in_reg_1/in_reg_2;
//   rename in_bank_enable/in_bank_reg/in_bank_tag; CDB in_CDB_broadcast/
//   in_CDB_tag/in_CDB_val; in_flush; registered read response out_enable,
//   out_val_1/2, out_tag_1/2.
module reg_status_table #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 5,
    parameter bit ZERO_REG = 1'b1,
    localparam int RIDX_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_enable,
    input  logic [RIDX_W-1:0] in_reg_1,
    input  logic [RIDX_W-1:0] in_reg_2,
    input  logic              in_bank_enable,
    input  logic [RIDX_W-1:0] in_bank_reg,
    input  logic [TAG_W-1:0]  in_bank_tag,
    input  logic              in_CDB_broadcast,
    input  logic [TAG_W-1:0]  in_CDB_tag,
    input  logic [DATA_W-1:0] in_CDB_val,
    input  logic              in_flush,
    output logic              out_enable,
    output logic [DATA_W-1:0] out_val_1,
    output logic [DATA_W-1:0] out_val_2,
    output logic [TAG_W-1:0]  out_tag_1,
    output logic [TAG_W-1:0]  out_tag_2
);

    localparam logic [TAG_W-1:0] INVALID_TAG = {TAG_W{1'b1}};

    logic [DATA_W-1:0] val_q [NUM_REGS];
    logic [DATA_W-1:0] val_d [NUM_REGS];
    logic [TAG_W-1:0]  tag_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_d [NUM_REGS];

    logic              out_enable_q;
    logic [DATA_W-1:0] out_val_q [2];
    logic [TAG_W-1:0]  out_tag_q [2];

    logic [RIDX_W-1:0] rd_idx [2];
    logic [DATA_W-1:0] rd_val [2];
    logic [TAG_W-1:0]  rd_tag [2];

    logic cdb_valid;

    // An INVALID_TAG broadcast would otherwise match every ready entry.
    assign cdb_valid = in_CDB_broadcast && (in_CDB_tag != INVALID_TAG);

    // Later assignments win: CDB < rename < flush < zero register.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            val_d[i] = val_q[i];
            tag_d[i] = tag_q[i];
            if (cdb_valid && tag_q[i] == in_CDB_tag) begin
                val_d[i] = in_CDB_val;
                tag_d[i] = INVALID_TAG;
            end
            if (in_bank_enable && in_bank_reg == RIDX_W'(i)) begin
                tag_d[i] = in_bank_tag;
            end
            if (in_flush) begin
                tag_d[i] = INVALID_TAG;
            end
            if (ZERO_REG && i == 0) begin
                val_d[i] = '0;
                tag_d[i] = INVALID_TAG;
            end
        end
    end

    assign rd_idx[0] = in_reg_1;
    assign rd_idx[1] = in_reg_2;

    // Reads see pre-edge state plus a same-cycle CDB hit; a same-cycle
    // rename is deliberately not forwarded.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = val_q[rd_idx[p]];
            rd_tag[p] = tag_q[rd_idx[p]];
            if (cdb_valid && tag_q[rd_idx[p]] == in_CDB_tag) begin
                rd_val[p] = in_CDB_val;
                rd_tag[p] = INVALID_TAG;
            end else if (in_flush) begin
                rd_tag[p] = INVALID_TAG;
            end
            if (ZERO_REG && rd_idx[p] == '0) begin
                rd_val[p] = '0;
                rd_tag[p] = INVALID_TAG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= INVALID_TAG;
            end
            out_enable_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                out_val_q[p] <= '0;
                out_tag_q[p] <= INVALID_TAG;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
            out_enable_q <= in_enable;
            if (in_enable) begin
                for (int p = 0; p < 2; p++) begin
                    out_val_q[p] <= rd_val[p];
                    out_tag_q[p] <= rd_tag[p];
                end
            end
        end
    end

    assign out_enable = out_enable_q;
    assign out_val_1  = out_val_q[0];
    assign out_val_2  = out_val_q[1];
    assign out_tag_1  = out_tag_q[0];
    assign out_tag_2  = out_tag_q[1];

endmodule

// File: tb/tb_reg_status_table.sv
// Testbench for reg_status_table: directed vector table followed by
// randomized traffic checked against a behavioural table model.
module tb_reg_status_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_enable;
    logic [4:0]  in_reg_1;
    logic [4:0]  in_reg_2;
    logic        in_bank_enable;
    logic [4:0]  in_bank_reg;
    logic [4:0]  in_bank_tag;
    logic        in_CDB_broadcast;
    logic [4:0]  in_CDB_tag;
    logic [31:0] in_CDB_val;
    logic        in_flush;
    logic        out_enable;
    logic [31:0] out_val_1;
    logic [31:0] out_val_2;
    logic [4:0]  out_tag_1;
    logic [4:0]  out_tag_2;

    int passed = 0;
    int total  = 0;

    reg_status_table dut (
        .clk              (clk),
        .rst              (rst),
        .in_enable        (in_enable),
        .in_reg_1         (in_reg_1),
        .in_reg_2         (in_reg_2),
        .in_bank_enable   (in_bank_enable),
        .in_bank_reg      (in_bank_reg),
        .in_bank_tag      (in_bank_tag),
        .in_CDB_broadcast (in_CDB_broadcast),
        .in_CDB_tag       (in_CDB_tag),
        .in_CDB_val       (in_CDB_val),
        .in_flush         (in_flush),
        .out_enable       (out_enable),
        .out_val_1        (out_val_1),
        .out_val_2        (out_val_2),
        .out_tag_1        (out_tag_1),
        .out_tag_2        (out_tag_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ben;
        logic [4:0]  breg;
        logic [4:0]  btag;
        logic        cb;
        logic [4:0]  ctag;
        logic [31:0] cval;
        logic        fl;
        logic        e_en;
        logic [31:0] e_v1;
        logic [4:0]  e_t1;
        logic [31:0] e_v2;
        logic [4:0]  e_t2;
    } vec_t;

    vec_t vq[$];

    function automatic void add(
        logic rst_, logic en, logic [4:0] r1, logic [4:0] r2,
        logic ben, logic [4:0] breg, logic [4:0] btag,
        logic cb, logic [4:0] ctag, logic [31:0] cval, logic fl,
        logic e_en, logic [31:0] e_v1, logic [4:0] e_t1,
        logic [31:0] e_v2, logic [4:0] e_t2);
        vec_t v;
        v.rst = rst_; v.en = en; v.r1 = r1; v.r2 = r2;
        v.ben = ben; v.breg = breg; v.btag = btag;
        v.cb = cb; v.ctag = ctag; v.cval = cval; v.fl = fl;
        v.e_en = e_en; v.e_v1 = e_v1; v.e_t1 = e_t1;
        v.e_v2 = e_v2; v.e_t2 = e_t2;
        vq.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(vec_t v);
        rst              = v.rst;
        in_enable        = v.en;
        in_reg_1         = v.r1;
        in_reg_2         = v.r2;
        in_bank_enable   = v.ben;
        in_bank_reg      = v.breg;
        in_bank_tag      = v.btag;
        in_CDB_broadcast = v.cb;
        in_CDB_tag       = v.ctag;
        in_CDB_val       = v.cval;
        in_flush         = v.fl;
    endtask

    task automatic check_out(string pfx, logic e_en, logic [31:0] e_v1,
                             logic [4:0] e_t1, logic [31:0] e_v2,
                             logic [4:0] e_t2);
        chk({pfx, " out_enable"}, 32'(out_enable), 32'(e_en));
        chk({pfx, " out_val_1"}, out_val_1, e_v1);
        chk({pfx, " out_tag_1"}, 32'(out_tag_1), 32'(e_t1));
        chk({pfx, " out_val_2"}, out_val_2, e_v2);
        chk({pfx, " out_tag_2"}, 32'(out_tag_2), 32'(e_t2));
    endtask

    // Behavioural model state.
    logic [31:0] mval [32];
    logic [4:0]  mtag [32];
    logic        m_en;
    logic [31:0] m_v [2];
    logic [4:0]  m_t [2];

    task automatic model_step(vec_t v);
        logic       hit [32];
        logic [4:0] idx [2];
        logic       live;
        idx[0] = v.r1;
        idx[1] = v.r2;
        live = v.cb && v.ctag != 5'h1F;
        if (v.rst) begin
            m_en = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_v[p] = 0;
                m_t[p] = 5'h1F;
            end
            for (int i = 0; i < 32; i++) begin
                mval[i] = 0;
                mtag[i] = 5'h1F;
            end
            return;
        end
        m_en = v.en;
        if (v.en) begin
            for (int p = 0; p < 2; p++) begin
                if (idx[p] == 0) begin
                    m_v[p] = 0; m_t[p] = 5'h1F;
                end else if (live && mtag[idx[p]] == v.ctag) begin
                    m_v[p] = v.cval; m_t[p] = 5'h1F;
                end else begin
                    m_v[p] = mval[idx[p]];
                    m_t[p] = v.fl ? 5'h1F : mtag[idx[p]];
                end
            end
        end
        for (int i = 0; i < 32; i++) hit[i] = live && mtag[i] == v.ctag;
        for (int i = 1; i < 32; i++) begin
            if (hit[i]) begin
                mval[i] = v.cval;
                mtag[i] = 5'h1F;
            end
        end
        if (v.fl) begin
            for (int i = 0; i < 32; i++) mtag[i] = 5'h1F;
        end else if (v.ben && v.breg != 0) begin
            mtag[v.breg] = v.btag;
        end
    endtask

    initial begin
        vec_t v;
        //  rst en r1 r2  ben breg btag  cb ctag cval  fl   e_en v1 t1 v2 t2
        add(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 3, 4,  0, 0, 0,  0, 0, 0, 0,  1, 0, 5'h1F, 0, 5'h1F);
        add(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 5'h1F, 0, 5'h1F);
        add(0, 0, 0, 0,  1, 5, 7,  0, 0, 0, 0,  0, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 5, 5,  0, 0, 0,  0, 0, 0, 0,  1, 0, 7, 0, 7);
        add(0, 0, 0, 0,  0, 0, 0,  1, 7, 32'h1234, 0,  0, 0, 7, 0, 7);
        add(0, 1, 5, 3,  0, 0, 0,  0, 0, 0, 0,  1, 32'h1234, 5'h1F, 0, 5'h1F);
        add(0, 0, 0, 0,  1, 2, 4,  0, 0, 0, 0,  0, 32'h1234, 5'h1F, 0, 5'h1F);
        add(0, 0, 0, 0,  1, 9, 4,  0, 0, 0, 0,  0, 32'h1234, 5'h1F, 0, 5'h1F);
        add(0, 1, 2, 9,  0, 0, 0,  1, 4, 32'hAA, 0,  1, 32'hAA, 5'h1F, 32'hAA, 5'h1F);
        add(0, 1, 2, 9,  0, 0, 0,  0, 0, 0, 0,  1, 32'hAA, 5'h1F, 32'hAA, 5'h1F);
        add(0, 0, 0, 0,  1, 6, 3,  0, 0, 0, 0,  0, 32'hAA, 5'h1F, 32'hAA, 5'h1F);
        add(0, 1, 6, 6,  1, 6, 3,  1, 3, 32'h55, 0,  1, 32'h55, 5'h1F, 32'h55, 5'h1F);
        add(0, 1, 6, 0,  0, 0, 0,  0, 0, 0, 0,  1, 32'h55, 3, 0, 5'h1F);
        add(0, 0, 0, 0,  1, 1, 2,  0, 0, 0, 0,  0, 32'h55, 3, 0, 5'h1F);
        add(0, 0, 0, 0,  1, 8, 9,  0, 0, 0, 0,  0, 32'h55, 3, 0, 5'h1F);
        add(0, 1, 1, 6,  0, 0, 0,  0, 0, 0, 1,  1, 0, 5'h1F, 32'h55, 5'h1F);
        add(0, 1, 1, 8,  0, 0, 0,  1, 2, 32'h77, 0,  1, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 1, 6,  0, 0, 0,  0, 0, 0, 0,  1, 0, 5'h1F, 32'h55, 5'h1F);
        add(0, 0, 0, 0,  1, 0, 1,  0, 0, 0, 0,  0, 0, 5'h1F, 32'h55, 5'h1F);
        add(0, 1, 0, 0,  0, 0, 0,  1, 1, 5, 0,  1, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 0, 5,  0, 0, 0,  0, 0, 0, 0,  1, 0, 5'h1F, 32'h1234, 5'h1F);
        add(1, 1, 5, 5,  0, 0, 0,  0, 0, 0, 0,  0, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 5, 5,  0, 0, 0,  0, 0, 0, 0,  1, 0, 5'h1F, 0, 5'h1F);
        add(0, 0, 0, 0,  1, 7, 6,  0, 0, 0, 1,  0, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 7, 7,  0, 0, 0,  0, 0, 0, 0,  1, 0, 5'h1F, 0, 5'h1F);
        add(0, 0, 0, 0,  1, 10, 8,  0, 0, 0, 0,  0, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 10, 10,  1, 10, 12,  0, 0, 0, 0,  1, 0, 8, 0, 8);
        add(0, 1, 10, 3,  0, 0, 0,  0, 0, 0, 0,  1, 0, 12, 0, 5'h1F);
        add(0, 1, 3, 3,  0, 0, 0,  1, 5'h1F, 32'h99, 0,  1, 0, 5'h1F, 0, 5'h1F);
        add(0, 1, 3, 10,  0, 0, 0,  0, 0, 0, 0,  1, 0, 5'h1F, 0, 12);

        v = vq[0];
        drive(v);
        for (int n = 0; n < vq.size(); n++) begin
            drive(vq[n]);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", n), vq[n].e_en, vq[n].e_v1,
                      vq[n].e_t1, vq[n].e_v2, vq[n].e_t2);
        end

        // Random traffic; the first cycle resets both DUT and model.
        for (int n = 0; n < 3000; n++) begin
            v.rst  = (n == 0) || ($urandom_range(0, 199) == 0);
            v.en   = $urandom_range(0, 2) != 0;
            v.r1   = 5'($urandom_range(0, 31));
            v.r2   = $urandom_range(0, 3) == 0 ? v.r1
                                               : 5'($urandom_range(0, 31));
            v.ben  = $urandom_range(0, 2) == 0;
            v.breg = 5'($urandom_range(0, 31));
            v.btag = 5'($urandom_range(0, 31));
            v.cb   = $urandom_range(0, 1) == 1;
            v.ctag = $urandom_range(0, 1) == 1
                   ? mtag[$urandom_range(0, 31)]
                   : 5'($urandom_range(0, 31));
            v.cval = $urandom;
            v.fl   = $urandom_range(0, 24) == 0;
            drive(v);
            model_step(v);
            @(posedge clk);
            #1;
            check_out($sformatf("rnd%0d", n), m_en, m_v[0], m_t[0],
                      m_v[1], m_t[1]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
Name: reg_status_table

Overview:
- Parametrised register status / rename table for the Tomasulo issue stage.
- Each architectural register holds a committed value plus a producer tag; INVALID_TAG means the value is ready.
- Issue reads two source operands and renames one destination per cycle.
- The CDB writes back results by tag match, and a flush input clears all pending tags after a mispredict.

Parameters:
- DATA_W, 32, operand/value width.
- NUM_REGS, 32, architectural registers; index width RIDX_W = clog2(NUM_REGS).
- TAG_W, 5, reservation-station tag width.
- INVALID_TAG, all-ones of TAG_W, meaning "no pending producer".
- ZERO_REG, 1, when 1 register 0 always reads value 0 and INVALID_TAG, and ignores rename and CDB writes.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_enable  in  1  read request; samples in_reg_1 and in_reg_2.
- in_reg_1  in  RIDX_W  source register 1 index.
- in_reg_2  in  RIDX_W  source register 2 index.
- in_bank_enable  in  1  rename request.
- in_bank_reg  in  RIDX_W  destination register to rename.
- in_bank_tag  in  TAG_W  new producer tag for that register.
- in_CDB_broadcast  in  1  CDB result valid.
- in_CDB_tag  in  TAG_W  tag of the broadcast result.
- in_CDB_val  in  DATA_W  value of the broadcast result.
- in_flush  in  1  set every tag to INVALID_TAG; values are kept.
- out_enable  out  1  read response valid, one-cycle pulse.
- out_val_1  out  DATA_W  source 1 value; meaningful only when out_tag_1 == INVALID_TAG.
- out_val_2  out  DATA_W  source 2 value.
- out_tag_1  out  TAG_W  source 1 pending tag, or INVALID_TAG.
- out_tag_2  out  TAG_W  source 2 pending tag, or INVALID_TAG.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Every entry becomes {value 0, INVALID_TAG}.
  - out_enable=0, out_val_* = 0, out_tag_* = INVALID_TAG.
  - Reset overrides every other input in that cycle.
- Read latency is 1 cycle.
  - in_enable high at edge N gives out_enable=1 after edge N, with outputs registered.
  - out_enable drops after edge N+1 unless in_enable is high again.
  - Back-to-back reads return back-to-back results. There is no stall and no backpressure.
  - out_val/out_tag hold their last values while out_enable=0.
- CDB writeback: when in_CDB_broadcast=1 and in_CDB_tag != INVALID_TAG, every entry i (0..NUM_REGS-1, all entries scanned) whose tag equals in_CDB_tag gets value <= in_CDB_val and tag <= INVALID_TAG.
  - A broadcast with tag == INVALID_TAG is ignored.
- Rename: when in_bank_enable=1, entry[in_bank_reg] gets tag <= in_bank_tag. Its value is unchanged and is stale until the CDB writes it.
- Precedence at the same edge: rst > in_flush > rename > CDB.
  - Rename and a matching CDB hit on the same register: the register ends with the new tag, and the value is updated from the CDB.
  - Flush together with CDB: matched values are still written and all tags become invalid.
  - Flush together with rename: the rename is dropped.
- Read bypass: reads see the pre-edge table state, except for a same-cycle CDB broadcast.
  - If a read index's current tag matches a valid broadcast tag, the output is in_CDB_val with INVALID_TAG.
  - A same-cycle rename is NOT visible to a read, so a source equal to the destination returns the older producer.
  - A same-cycle flush makes the read return the stored value with INVALID_TAG.
- ZERO_REG=1: reads of register 0 return {0, INVALID_TAG}. Rename and CDB writes to entry 0 are discarded.
- Both read ports may use the same index; they return identical results.
- Multiple entries holding the same tag are all updated by one broadcast.

Test Plan:
- Reset, then read r3/r4 -> out_enable pulses 1 cycle later; outputs {0, 0x1F} on both ports.
- Rename r5 to tag 7, then read r5 -> out_tag_1=7. CDB tag 7 val 0x1234, then read r5 -> val 0x1234, tag 0x1F.
- Rename r2 and r9 both to tag 4; broadcast tag 4 val 0xAA -> both read 0xAA/invalid. Read r2 in the same cycle as the broadcast -> bypass returns 0xAA/0x1F.
- Rename r6 to tag 3 at the same edge as CDB tag 3 targeting old tag 3 on r6 -> r6 tag stays 3 and the value is updated. Same-cycle read of r6 returns the bypassed CDB value.
- Rename r1 to tag 2, r8 to tag 9, then assert in_flush -> reads return stored values with 0x1F. A later CDB tag 2 changes nothing.
- ZERO_REG=1: rename r0 to tag 1, broadcast tag 1 val 5 -> r0 reads {0, 0x1F}. Assert rst during an in_enable pulse -> out_enable=0 after that edge.
